// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator for the decode stage.
// Builds an XLEN-wide immediate from a 32-bit instruction (I/S/SB/U/UJ, CSR
// zimm, shift amount) and presents it through a 2-entry skid buffer with
// 1-cycle latency and full throughput.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   flush                synchronous flush, drops both held entries
//   in_valid/in_ready    upstream handshake (in_ready registered)
//   in_instr             raw instruction word
//   in_imm_type          immediate type (ignored when AUTO_DECODE=1)
//   out_valid/out_ready  downstream handshake
//   out_imm              generated immediate, XLEN bits
//   out_type             resolved immediate type
//   out_illegal          type 111 / unknown opcode; out_imm is 0 then
module imm_gen_pipe #(
  parameter int unsigned XLEN        = 64,
  parameter bit          AUTO_DECODE = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_imm_type,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic            out_illegal
);

  localparam logic [2:0] T_I    = 3'b000;
  localparam logic [2:0] T_S    = 3'b001;
  localparam logic [2:0] T_SB   = 3'b010;
  localparam logic [2:0] T_U    = 3'b011;
  localparam logic [2:0] T_UJ   = 3'b100;
  localparam logic [2:0] T_Z    = 3'b101;
  localparam logic [2:0] T_SHMT = 3'b110;
  localparam logic [2:0] T_BAD  = 3'b111;

  logic [6:0]         w_opcode;
  logic [2:0]         w_funct3;
  logic [2:0]         w_dec_type;
  logic               w_word_shamt;
  logic [2:0]         w_type;
  logic               w_shamt5;
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]    w_imm;
  logic               w_illegal;
  logic               w_accept;

  logic               r_main_valid;
  logic [XLEN-1:0]    r_main_imm;
  logic [2:0]         r_main_type;
  logic               r_main_illegal;
  logic               r_skid_valid;
  logic [XLEN-1:0]    r_skid_imm;
  logic [2:0]         r_skid_type;
  logic               r_skid_illegal;
  logic               r_in_ready;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];

  // Opcode-driven type decode; the W-form shifts carry a 5-bit shamt.
  always_comb begin
    w_dec_type   = T_BAD;
    w_word_shamt = 1'b0;
    case (w_opcode)
      7'b0000011, 7'b1100111: w_dec_type = T_I;
      7'b0010011: w_dec_type = (w_funct3[1:0] == 2'b01) ? T_SHMT : T_I;
      7'b0011011: begin
        if (XLEN == 64) begin
          w_dec_type   = (w_funct3[1:0] == 2'b01) ? T_SHMT : T_I;
          w_word_shamt = 1'b1;
        end
      end
      7'b0100011: w_dec_type = T_S;
      7'b1100011: w_dec_type = T_SB;
      7'b0110111, 7'b0010111: w_dec_type = T_U;
      7'b1101111: w_dec_type = T_UJ;
      7'b1110011: w_dec_type = w_funct3[2] ? T_Z : T_I;
      default: w_dec_type = T_BAD;
    endcase
  end

  assign w_type    = AUTO_DECODE ? w_dec_type : in_imm_type;
  assign w_shamt5  = (XLEN == 32) || (AUTO_DECODE && w_word_shamt);
  assign w_illegal = (w_type == T_BAD);

  // Every form fits in 32 bits; the signed widening cast below gives the
  // XLEN sign extension (zero-extended forms have a clear bit 31).
  always_comb begin
    w_imm32 = '0;
    case (w_type)
      T_I:    w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      T_S:    w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      T_SB:   w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
      T_U:    w_imm32 = {in_instr[31:12], 12'b0};
      T_UJ:   w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
      T_Z:    w_imm32 = {27'b0, in_instr[19:15]};
      T_SHMT: w_imm32 = w_shamt5 ? {27'b0, in_instr[24:20]} : {26'b0, in_instr[25:20]};
      default: w_imm32 = '0;
    endcase
  end

  assign w_imm    = XLEN'(w_imm32);
  assign w_accept = in_valid && r_in_ready;

  // Two-entry skid buffer: main drives the outputs, skid catches one word
  // while main is stalled. in_ready is simply "skid is empty".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_valid   <= 1'b0;
      r_main_imm     <= '0;
      r_main_type    <= '0;
      r_main_illegal <= 1'b0;
      r_skid_valid   <= 1'b0;
      r_skid_imm     <= '0;
      r_skid_type    <= '0;
      r_skid_illegal <= 1'b0;
      r_in_ready     <= 1'b1;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (!r_main_valid || out_ready) begin
      // Main is free this edge: refill from skid first to keep FIFO order.
      if (r_skid_valid) begin
        r_main_valid   <= 1'b1;
        r_main_imm     <= r_skid_imm;
        r_main_type    <= r_skid_type;
        r_main_illegal <= r_skid_illegal;
        r_skid_valid   <= 1'b0;
        r_in_ready     <= 1'b1;
      end else begin
        r_main_valid <= w_accept;
        if (w_accept) begin
          r_main_imm     <= w_imm;
          r_main_type    <= w_type;
          r_main_illegal <= w_illegal;
        end
      end
    end else if (w_accept) begin
      r_skid_valid   <= 1'b1;
      r_skid_imm     <= w_imm;
      r_skid_type    <= w_type;
      r_skid_illegal <= w_illegal;
      r_in_ready     <= 1'b0;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_main_valid;
  assign out_imm     = r_main_imm;
  assign out_type    = r_main_type;
  assign out_illegal = r_main_illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe.
// u_man: XLEN=64 with explicit type; u_auto: XLEN=64 with opcode decode.
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;

  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_illegal;
  logic [31:0] m_in_instr;
  logic [2:0]  m_in_type, m_out_type;
  logic [63:0] m_out_imm;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [31:0] a_in_instr;
  logic [2:0]  a_in_type, a_out_type;
  logic [63:0] a_out_imm;

  exp_t q_m[$];
  exp_t q_a[$];
  int   n_tests;
  int   n_fail;
  int   stalls;
  int   a_drained;

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b0)) u_man (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_instr(m_in_instr),
    .in_imm_type(m_in_type),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_imm(m_out_imm),
    .out_type(m_out_type), .out_illegal(m_out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) u_auto (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr),
    .in_imm_type(a_in_type),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
    .out_type(a_out_type), .out_illegal(a_out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: one check per output handshake, in FIFO order.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && m_out_valid && m_out_ready) begin
      n_tests++;
      if (q_m.size() == 0) begin
        n_fail++;
        $display("FAIL man_unexpected: imm=%h type=%0d with empty scoreboard", m_out_imm, m_out_type);
      end else begin
        e = q_m.pop_front();
        if (m_out_imm !== e.imm || m_out_type !== e.typ || m_out_illegal !== e.ill) begin
          n_fail++;
          $display("FAIL man_out: got imm=%h type=%0d ill=%0d, expected imm=%h type=%0d ill=%0d",
                   m_out_imm, m_out_type, m_out_illegal, e.imm, e.typ, e.ill);
        end
      end
    end
    if (!rst && a_out_valid && a_out_ready) begin
      n_tests++;
      a_drained++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL auto_unexpected: imm=%h type=%0d with empty scoreboard", a_out_imm, a_out_type);
      end else begin
        e = q_a.pop_front();
        if (a_out_imm !== e.imm || a_out_type !== e.typ || a_out_illegal !== e.ill) begin
          n_fail++;
          $display("FAIL auto_out: got imm=%h type=%0d ill=%0d, expected imm=%h type=%0d ill=%0d",
                   a_out_imm, a_out_type, a_out_illegal, e.imm, e.typ, e.ill);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Offer one word; returns just after the accepting edge with in_valid still
  // high, so consecutive calls stream without a bubble.
  task automatic send(input bit sel, input logic [31:0] instr, input logic [2:0] typ,
                      input logic [63:0] e_imm, input logic [2:0] e_typ, input logic e_ill);
    bit   rdy;
    bit   done;
    exp_t e;
    done = 1'b0;
    @(negedge clk);
    if (sel) begin
      a_in_valid = 1'b1; a_in_instr = instr; a_in_type = typ;
    end else begin
      m_in_valid = 1'b1; m_in_instr = instr; m_in_type = typ;
    end
    for (int k = 0; k < 64 && !done; k++) begin
      rdy = sel ? a_in_ready : m_in_ready;
      @(posedge clk);
      if (rdy) done = 1'b1;
      else begin
        stalls++;
        @(negedge clk);
      end
    end
    if (done) begin
      e.imm = e_imm; e.typ = e_typ; e.ill = e_ill;
      if (sel) q_a.push_back(e);
      else     q_m.push_back(e);
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: instr=%h never accepted", instr);
    end
  endtask

  task automatic drop();
    @(negedge clk);
    m_in_valid = 1'b0;
    a_in_valid = 1'b0;
  endtask

  task automatic sendm(input logic [31:0] instr, input logic [2:0] typ,
                       input logic [63:0] e_imm, input logic e_ill);
    send(1'b0, instr, typ, e_imm, typ, e_ill);
  endtask

  task automatic senda(input logic [31:0] instr, input logic [63:0] e_imm,
                       input logic [2:0] e_typ, input logic e_ill);
    send(1'b1, instr, 3'd3, e_imm, e_typ, e_ill);
  endtask

  initial begin
    int base;
    rst = 1'b1; flush = 1'b0;
    m_in_valid = 1'b0; m_in_instr = '0; m_in_type = '0; m_out_ready = 1'b0;
    a_in_valid = 1'b0; a_in_instr = '0; a_in_type = '0; a_out_ready = 1'b0;
    n_tests = 0; n_fail = 0; stalls = 0; a_drained = 0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready",    64'(m_in_ready), 64'd1);
    chk("rst_out_valid",   64'(m_out_valid), 64'd0);
    chk("rst_out_imm",     m_out_imm, 64'd0);
    chk("rst_out_type",    64'(m_out_type), 64'd0);
    chk("rst_out_illegal", 64'(m_out_illegal), 64'd0);
    chk("rst_auto_valid",  64'(a_out_valid), 64'd0);
    rst = 1'b0;
    m_out_ready = 1'b1;
    a_out_ready = 1'b1;

    // Explicit-type vectors.
    sendm(32'hFFF00093, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    sendm(32'h7FF00013, 3'd0, 64'h0000_0000_0000_07FF, 1'b0);
    sendm(32'h800000B7, 3'd3, 64'hFFFF_FFFF_8000_0000, 1'b0);
    sendm(32'hFE000E23, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    sendm(32'hFE000FE3, 3'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    sendm(32'h000000E3, 3'd2, 64'h0000_0000_0000_0800, 1'b0);
    sendm(32'h0010006F, 3'd4, 64'h0000_0000_0000_0800, 1'b0);
    sendm(32'h000FF06F, 3'd4, 64'h0000_0000_000F_F000, 1'b0);
    sendm(32'h7FE0006F, 3'd4, 64'h0000_0000_0000_07FE, 1'b0);
    sendm(32'h8000006F, 3'd4, 64'hFFFF_FFFF_FFF0_0000, 1'b0);
    sendm(32'h800F8073, 3'd5, 64'h0000_0000_0000_001F, 1'b0);
    sendm(32'h03F09093, 3'd6, 64'd63, 1'b0);
    sendm(32'h82000013, 3'd6, 64'd32, 1'b0);
    sendm(32'hFFFFFFFF, 3'd7, 64'd0, 1'b1);
    drop();

    // Opcode-decoded vectors (in_imm_type held at a misleading value).
    senda(32'h03F09093, 64'd63, 3'd6, 1'b0);
    senda(32'h0000007F, 64'd0, 3'd7, 1'b1);
    senda(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0);
    senda(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd3, 1'b0);
    senda(32'h0010006F, 64'h0000_0000_0000_0800, 3'd4, 1'b0);
    senda(32'hFE000E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0);
    senda(32'h000000E3, 64'h0000_0000_0000_0800, 3'd2, 1'b0);
    senda(32'h000FD073, 64'h0000_0000_0000_001F, 3'd5, 1'b0);
    senda(32'hFFF01073, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0);
    senda(32'h03F0101B, 64'd31, 3'd6, 1'b0);
    senda(32'h8000001B, 64'hFFFF_FFFF_FFFF_F800, 3'd0, 1'b0);
    senda(32'h40105013, 64'd1, 3'd6, 1'b0);
    senda(32'hFFC03003, 64'hFFFF_FFFF_FFFF_FFFC, 3'd0, 1'b0);
    senda(32'h00400067, 64'd4, 3'd0, 1'b0);
    senda(32'h00001017, 64'h0000_0000_0000_1000, 3'd3, 1'b0);
    drop();
    repeat (3) @(negedge clk);

    // Streaming: 20 back-to-back words, no input stall, 20 outputs.
    stalls = 0;
    base = a_drained;
    for (int i = 0; i < 20; i++) begin
      logic [11:0] v;
      v = 12'(i * 12'h0B7 + 12'h7F0);
      senda({v, 20'h00093}, {{52{v[11]}}, v}, 3'd0, 1'b0);
    end
    drop();
    repeat (2) @(negedge clk);
    chk("stream_stalls", 64'(stalls), 64'd0);
    chk("stream_count", 64'(a_drained - base), 64'd20);

    // Backpressure: two words held, third waits until downstream resumes.
    m_out_ready = 1'b0;
    sendm(32'h00100013, 3'd0, 64'd1, 1'b0);
    sendm(32'h00200013, 3'd0, 64'd2, 1'b0);
    @(negedge clk);
    chk("bp_in_ready", 64'(m_in_ready), 64'd0);
    chk("bp_out_valid", 64'(m_out_valid), 64'd1);
    chk("bp_head_imm", m_out_imm, 64'd1);
    fork
      sendm(32'h00300013, 3'd0, 64'd3, 1'b0);
      begin
        repeat (3) @(negedge clk);
        chk("bp_hold_imm", m_out_imm, 64'd1);
        chk("bp_hold_ready", 64'(m_in_ready), 64'd0);
        m_out_ready = 1'b1;
      end
    join
    drop();
    repeat (4) @(negedge clk);
    chk("bp_drained", 64'(q_m.size()), 64'd0);

    // Flush with both entries held.
    m_out_ready = 1'b0;
    sendm(32'h00400013, 3'd0, 64'd4, 1'b0);
    sendm(32'h00500013, 3'd0, 64'd5, 1'b0);
    drop();
    chk("fl_pre_ready", 64'(m_in_ready), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    q_m.delete();
    chk("fl_out_valid", 64'(m_out_valid), 64'd0);
    chk("fl_in_ready", 64'(m_in_ready), 64'd1);
    // A handshake in the flush cycle is dropped.
    m_in_valid = 1'b1; m_in_instr = 32'h00600013; m_in_type = 3'd0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_in_valid = 1'b0;
    chk("fl_hs_dropped", 64'(m_out_valid), 64'd0);
    m_out_ready = 1'b1;
    sendm(32'h00700013, 3'd0, 64'd7, 1'b0);
    drop();
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-stream clears outputs without a clock edge.
    m_out_ready = 1'b0;
    sendm(32'h800000B7, 3'd3, 64'hFFFF_FFFF_8000_0000, 1'b0);
    sendm(32'hFFF00093, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    drop();
    chk("ar_pre_valid", 64'(m_out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", 64'(m_out_valid), 64'd0);
    chk("ar_out_imm", m_out_imm, 64'd0);
    chk("ar_out_type", 64'(m_out_type), 64'd0);
    chk("ar_in_ready", 64'(m_in_ready), 64'd1);
    q_m.delete();
    q_a.delete();
    @(negedge clk);
    rst = 1'b0;
    m_out_ready = 1'b1;
    sendm(32'hFE000E23, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    drop();

    for (int i = 0; i < 20 && (q_m.size() != 0 || q_a.size() != 0); i++) @(negedge clk);
    chk("end_q_man", 64'(q_m.size()), 64'd0);
    chk("end_q_auto", 64'(q_a.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
